store_fwd_buffer: RTL and testbench
===================================

STORE_FWD_BUFFER -- requirements
Module: store_fwd_buffer

Interface
REQ-001 Parameter DATA_W, default 32, store/load data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter DEPTH, default 4, store buffer entries; SHALL be a power of two, at least 2.
REQ-004 Parameter NUM_FWD, default 2, forwarded write-back data channels.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 st_valid  in  1  store request from MEM stage.
REQ-008 st_ready  out  1  buffer accepts store this cycle.
REQ-009 st_addr  in  ADDR_W  store byte address.
REQ-010 st_strb  in  DATA_W/8  store byte enables.
REQ-011 st_data_exe  in  DATA_W  store operand from EXE/MEM register.
REQ-012 fwd_data  in  NUM_FWD*DATA_W  forwarded data; channel k at bits [k*DATA_W +: DATA_W].
REQ-013 fwd_sel  in  $clog2(NUM_FWD+1)  0 selects st_data_exe; k selects channel k-1.
REQ-014 ld_valid  in  1  load lookup request; ld_addr  in  ADDR_W  load byte address.
REQ-015 ld_hit  out  1  full-word forward available; ld_data  out  DATA_W  forwarded load data.
REQ-016 ld_partial  out  1  matching entry lacks full strobes; pipeline SHALL stall.
REQ-017 dc_req  out  1  write request to Dcache; dc_addr  out  ADDR_W; dc_data  out  DATA_W; dc_strb  out  DATA_W/8.
REQ-018 dc_ack  in  1  Dcache accepted head write.
REQ-019 empty  out  1; full  out  1  occupancy flags.

Function
REQ-020 Store data SHALL be chosen by fwd_sel; fwd_sel > NUM_FWD SHALL select st_data_exe.
REQ-021 Storage SHALL be an in-order FIFO of {addr, data, strb}; push on st_valid && st_ready, pop on dc_req && dc_ack.
REQ-022 st_ready SHALL equal !full; no push SHALL occur when full, even if a pop occurs in the same cycle.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 dc_req SHALL equal !empty; dc_addr/dc_data/dc_strb SHALL present the head entry and SHALL be held stable until dc_ack.
REQ-025 Store-to-Dcache latency SHALL be one cycle: a push in cycle N gives dc_req=1 in cycle N+1 when the buffer was empty.
REQ-026 Load match SHALL compare ld_addr[ADDR_W-1:$clog2(DATA_W/8)] against every valid entry, combinationally, only when ld_valid=1.
REQ-027 The newest matching entry SHALL win; if its strb is all-ones: ld_hit=1, ld_data=entry data; otherwise ld_partial=1, ld_hit=0.
REQ-028 Head entry being popped this cycle SHALL still participate in matching; an entry pushed this cycle SHALL NOT be visible until the next cycle.
REQ-029 ld_hit, ld_partial and ld_data SHALL be 0 when ld_valid=0 or when no entry matches.
REQ-030 empty SHALL equal (count==0); full SHALL equal (count==DEPTH); count SHALL be $clog2(DEPTH)+1 bits wide.

Reset
REQ-031 While rst=1: count, pointers and all entry valid bits SHALL be 0; empty=1, full=0, st_ready=1, dc_req=0, ld_hit=0, ld_partial=0.
REQ-032 Reset asserted mid-drain SHALL discard all buffered stores; dc_req SHALL be 0 from the cycle after the rst edge; entry data/addr storage need not be reset.

Configuration
REQ-033 Macro STORE_FWD_LD_BYPASS_EN defined: REQ-026..REQ-029 behaviour as specified.
REQ-034 Macro STORE_FWD_LD_BYPASS_EN undefined: ld_hit=0 and ld_data=0 constantly; ld_partial=1 on any word-address match with ld_valid=1 (conservative stall).

Structure
REQ-035 Package store_fwd_pkg SHALL hold the entry struct typedef {addr, data, strb} and the default parameter constants.
REQ-036 Sub-module store_data_sel SHALL implement the NUM_FWD+1-way store-data mux of REQ-020; the FIFO and match logic SHALL stay in store_fwd_buffer.

Verification
REQ-037 Reset, then store addr 0x100, data 0xAABBCCDD, fwd_sel=0, dc_ack=0 -> dc_req=1 next cycle with dc_addr 0x100 held until dc_ack.
REQ-038 fwd_sel=2, fwd_data channel1=0x12345678 -> buffered data 0x12345678; fwd_sel=3 (NUM_FWD=2) -> st_data_exe stored.
REQ-039 Push 4 stores with dc_ack=0 -> full=1, st_ready=0; fifth st_valid is not accepted; single dc_ack -> full=0 next cycle; order preserved across pointer wrap.
REQ-040 Stores 0x200 = 0x11 then 0x200 = 0x22 (strb 0xF), load 0x202 -> ld_hit=1, ld_data=0x22; store 0x300 with strb 0x3, load 0x300 -> ld_partial=1, ld_hit=0.
REQ-041 Simultaneous push and dc_ack with count=2 -> count stays 2; rst during pending dc_req -> empty=1, dc_req=0 next cycle.
REQ-042 Build without STORE_FWD_LD_BYPASS_EN, rerun REQ-040 -> ld_hit=0, ld_partial=1 for both loads.

Source files
------------

// File: rtl/store_fwd_pkg.sv
// Shared constants and entry layout for the store forwarding buffer.
package store_fwd_pkg;

   localparam int SFB_DATA_W  = 32;
   localparam int SFB_ADDR_W  = 32;
   localparam int SFB_DEPTH   = 4;
   localparam int SFB_NUM_FWD = 2;

   typedef struct packed {
      logic [SFB_ADDR_W-1:0]   addr;
      logic [SFB_DATA_W-1:0]   data;
      logic [SFB_DATA_W/8-1:0] strb;
   } sfb_entry_t;

endpackage

// File: rtl/store_data_sel.sv
// Store operand mux: picks EXE data or one of the write-back forward channels.
module store_data_sel
   import store_fwd_pkg::*;
#(
   parameter int DATA_W  = SFB_DATA_W,
   parameter int NUM_FWD = SFB_NUM_FWD
) (
   input  logic [NUM_FWD*DATA_W-1:0]      fwd_data,
   input  logic [$clog2(NUM_FWD+1)-1:0]   fwd_sel,
   input  logic [DATA_W-1:0]              st_data_exe,
   output logic [DATA_W-1:0]              sel_data
);

   // Out-of-range selects fall through to the EXE operand.
   always_comb begin
      sel_data = st_data_exe;
      for (int k = 1; k <= NUM_FWD; k++) begin
         if (int'(fwd_sel) == k) sel_data = fwd_data[(k-1)*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/store_fwd_buffer.sv
// In-order store buffer draining to the Dcache, with load lookup.
// Build option: STORE_FWD_LD_BYPASS_EN enables full-word load forwarding.
module store_fwd_buffer
   import store_fwd_pkg::*;
#(
   parameter int DATA_W  = SFB_DATA_W,
   parameter int ADDR_W  = SFB_ADDR_W,
   parameter int DEPTH   = SFB_DEPTH,
   parameter int NUM_FWD = SFB_NUM_FWD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          st_valid,
   output logic                          st_ready,
   input  logic [ADDR_W-1:0]             st_addr,
   input  logic [DATA_W/8-1:0]           st_strb,
   input  logic [DATA_W-1:0]             st_data_exe,
   input  logic [NUM_FWD*DATA_W-1:0]     fwd_data,
   input  logic [$clog2(NUM_FWD+1)-1:0]  fwd_sel,
   input  logic                          ld_valid,
   input  logic [ADDR_W-1:0]             ld_addr,
   output logic                          ld_hit,
   output logic [DATA_W-1:0]             ld_data,
   output logic                          ld_partial,
   output logic                          dc_req,
   output logic [ADDR_W-1:0]             dc_addr,
   output logic [DATA_W-1:0]             dc_data,
   output logic [DATA_W/8-1:0]           dc_strb,
   input  logic                          dc_ack,
   output logic                          empty,
   output logic                          full
);

   localparam int STRB_W = DATA_W/8;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int OFS_W  = $clog2(STRB_W);

   // Same field order as sfb_entry_t, sized to this instance.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] st_data;
   logic              push, pop;

   store_data_sel #(
      .DATA_W  (DATA_W),
      .NUM_FWD (NUM_FWD)
   ) u_data_sel (
      .fwd_data    (fwd_data),
      .fwd_sel     (fwd_sel),
      .st_data_exe (st_data_exe),
      .sel_data    (st_data)
   );

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign st_ready = !full;
   assign push     = st_valid && !full;
   assign pop      = !empty && dc_ack;

   assign dc_req  = !empty;
   assign dc_addr = mem[rd_ptr].addr;
   assign dc_data = mem[rd_ptr].data;
   assign dc_strb = mem[rd_ptr].strb;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage carries no reset; validity lives in vld.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: st_addr, data: st_data, strb: st_strb};
   end

   // Walk entries oldest to newest so the newest match is the one kept.
   logic              hit_any;
   logic [PTR_W-1:0]  idx;
`ifdef STORE_FWD_LD_BYPASS_EN
   logic [DATA_W-1:0] hit_data;
   logic              hit_full;
`endif

   always_comb begin
      hit_any = 1'b0;
      idx     = '0;
`ifdef STORE_FWD_LD_BYPASS_EN
      hit_data = '0;
      hit_full = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (vld[idx] && (mem[idx].addr[ADDR_W-1:OFS_W] == ld_addr[ADDR_W-1:OFS_W])) begin
            hit_any = 1'b1;
`ifdef STORE_FWD_LD_BYPASS_EN
            hit_data = mem[idx].data;
            hit_full = &mem[idx].strb;
`endif
         end
      end
      if (!ld_valid) hit_any = 1'b0;
   end

`ifdef STORE_FWD_LD_BYPASS_EN
   assign ld_hit     = hit_any && hit_full;
   assign ld_partial = hit_any && !hit_full;
   assign ld_data    = ld_hit ? hit_data : '0;
`else
   // Without bypass any word match stalls the load until the store drains.
   assign ld_hit     = 1'b0;
   assign ld_partial = hit_any;
   assign ld_data    = '0;
`endif

   logic unused_ld_ofs;
   assign unused_ld_ofs = ^ld_addr;

endmodule

// File: tb/tb_store_fwd_buffer.sv
// Directed bench for store_fwd_buffer; expectations follow STORE_FWD_LD_BYPASS_EN.
module tb_store_fwd_buffer;

`ifdef STORE_FWD_LD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data_exe;
   logic [3:0]  st_strb;
   logic [63:0] fwd_data;
   logic [1:0]  fwd_sel;
   logic        ld_valid, ld_hit, ld_partial;
   logic [31:0] ld_addr, ld_data;
   logic        dc_req, dc_ack;
   logic [31:0] dc_addr, dc_data;
   logic [3:0]  dc_strb;
   logic        empty, full;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   store_fwd_buffer dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_strb(st_strb),
      .st_data_exe(st_data_exe), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
      .ld_partial(ld_partial), .dc_req(dc_req), .dc_addr(dc_addr), .dc_data(dc_data),
      .dc_strb(dc_strb), .dc_ack(dc_ack), .empty(empty), .full(full)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] sel);
      st_valid = 1'b1; st_addr = a; st_data_exe = d; st_strb = s; fwd_sel = sel;
      tick;
      st_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input logic [31:0] a, input logic [31:0] d);
      chk({tag, "_req"}, dc_req, 1);
      chk({tag, "_addr"}, dc_addr, a);
      chk({tag, "_data"}, dc_data, d);
      dc_ack = 1'b1;
      tick;
      dc_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; st_valid = 0; st_addr = 0; st_strb = 4'hF; st_data_exe = 0;
      fwd_data = {32'h1234_5678, 32'hDEAD_BEEF}; fwd_sel = 0;
      ld_valid = 1'b1; ld_addr = 32'h100; dc_ack = 0;
      repeat (3) tick;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", st_ready, 1);
      chk("rst_dcreq", dc_req, 0);
      chk("rst_hit", ld_hit, 0);
      chk("rst_partial", ld_partial, 0);
      rst = 1'b0;
      ld_valid = 1'b0;
      tick;

      // one-cycle latency to Dcache, head held until ack
      push(32'h100, 32'hAABB_CCDD, 4'hF, 2'd0);
      chk("lat_req", dc_req, 1);
      chk("lat_addr", dc_addr, 32'h100);
      chk("lat_data", dc_data, 32'hAABB_CCDD);
      chk("lat_strb", dc_strb, 4'hF);
      tick;
      chk("hold_addr", dc_addr, 32'h100);
      drain("hold", 32'h100, 32'hAABB_CCDD);
      chk("drain_empty", empty, 1);

      // store data source selection
      push(32'h104, 32'h0BAD_F00D, 4'hF, 2'd2);
      push(32'h108, 32'hCAFE_0001, 4'hF, 2'd3);
      push(32'h10C, 32'h0BAD_F00D, 4'hF, 2'd1);
      drain("sel2", 32'h104, 32'h1234_5678);
      drain("sel3", 32'h108, 32'hCAFE_0001);
      drain("sel1", 32'h10C, 32'hDEAD_BEEF);

      // fill, blocked fifth store (also during a pop), wrap
      for (int i = 0; i < 4; i++) push(32'h400 + 4*i, 32'h1000 + i, 4'hF, 2'd0);
      chk("full_flag", full, 1);
      chk("full_ready", st_ready, 0);
      st_valid = 1'b1; st_addr = 32'h4F0; st_data_exe = 32'h9999;
      tick;
      chk("full_hold", full, 1);
      dc_ack = 1'b1;
      tick;
      st_valid = 1'b0; dc_ack = 1'b0;
      chk("full_clear", full, 0);
      chk("full_ready2", st_ready, 1);
      push(32'h410, 32'h1004, 4'hF, 2'd0);
      chk("wrap_full", full, 1);
      drain("wrap1", 32'h404, 32'h1001);
      drain("wrap2", 32'h408, 32'h1002);
      drain("wrap3", 32'h40C, 32'h1003);
      drain("wrap4", 32'h410, 32'h1004);
      chk("wrap_empty", empty, 1);

      // load lookup
      ld_valid = 1'b1; ld_addr = 32'h200;
      st_valid = 1'b1; st_addr = 32'h200; st_data_exe = 32'h11; st_strb = 4'hF; fwd_sel = 0;
      #1;
      chk("ld_newpush_hit", ld_hit, 0);
      chk("ld_newpush_part", ld_partial, 0);
      tick;
      st_valid = 1'b0;
      push(32'h200, 32'h22, 4'hF, 2'd0);
      ld_addr = 32'h202; #1;
      chk("ld_full_hit", ld_hit, BYP);
      chk("ld_full_data", ld_data, BYP ? 32'h22 : 32'h0);
      chk("ld_full_part", ld_partial, !BYP);
      ld_valid = 1'b0; #1;
      chk("ld_off_hit", ld_hit, 0);
      chk("ld_off_part", ld_partial, 0);
      chk("ld_off_data", ld_data, 0);
      ld_valid = 1'b1; ld_addr = 32'h500; #1;
      chk("ld_miss_hit", ld_hit, 0);
      chk("ld_miss_part", ld_partial, 0);
      push(32'h300, 32'hABCD, 4'h3, 2'd0);
      ld_addr = 32'h300; #1;
      chk("ld_part_part", ld_partial, 1);
      chk("ld_part_hit", ld_hit, 0);
      chk("ld_part_data", ld_data, 0);
      drain("ld_d1", 32'h200, 32'h11);
      drain("ld_d2", 32'h200, 32'h22);
      dc_ack = 1'b1; #1;
      chk("ld_pophead_part", ld_partial, 1);
      tick;
      dc_ack = 1'b0; #1;
      chk("ld_popped_part", ld_partial, 0);
      chk("ld_popped_empty", empty, 1);

      // concurrent push/pop at count 2, then reset mid-drain
      ld_valid = 1'b0;
      push(32'h600, 32'h6000, 4'hF, 2'd0);
      push(32'h604, 32'h6004, 4'hF, 2'd0);
      st_valid = 1'b1; st_addr = 32'h608; st_data_exe = 32'h6008; dc_ack = 1'b1;
      tick;
      st_valid = 1'b0; dc_ack = 1'b0;
      chk("pp_head", dc_addr, 32'h604);
      push(32'h60C, 32'h600C, 4'hF, 2'd0);
      chk("pp_cnt3_full", full, 0);
      push(32'h610, 32'h6010, 4'hF, 2'd0);
      chk("pp_cnt4_full", full, 1);
      rst = 1'b1;
      tick;
      chk("mid_rst_dcreq", dc_req, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_full", full, 0);
      ld_valid = 1'b1; ld_addr = 32'h604; #1;
      chk("mid_rst_part", ld_partial, 0);
      rst = 1'b0;
      tick;
      chk("post_rst_empty", empty, 1);
      chk("post_rst_part", ld_partial, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
